bus_rr_arbiter: RTL and testbench



---
 rtl/bus_arb_pkg.sv | 16 +
 rtl/bus_rr_pick.sv | 34 +++
 rtl/bus_rr_arbiter.sv | 135 +++++++++++++
 tb/tb_bus_rr_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types for the round-robin bus arbiter: FSM state encoding and the
// command record at the default bus widths.
package bus_arb_pkg;

  localparam int unsigned PKG_ADDR_WIDTH = 32;
  localparam int unsigned PKG_DATA_WIDTH = 8;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_RESP} arb_state_t;

  typedef struct packed {
    logic [PKG_ADDR_WIDTH-1:0] addr;
    logic [PKG_DATA_WIDTH-1:0] data;
    logic                      write_enable;
  } bus_cmd_t;

endpackage

// File: rtl/bus_rr_pick.sv
// Combinational rotating-priority picker: first set request bit searching
// upward from (last_grant+1) mod NUM_REQ, with wrap.
module bus_rr_pick
  import bus_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_any
);

  logic [IDX_W-1:0] cand;

  // Walk the candidates in priority order; the first hit wins
  always_comb begin
    gnt     = '0;
    gnt_idx = last_grant;
    gnt_any = 1'b0;
    cand    = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = IDX_W'((32'(last_grant) + off) % NUM_REQ);
      if (!gnt_any && req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter sharing one bus_if master port between NUM_REQ
// requesters. One single-beat command in flight at a time.
// Optional feature: BUS_RR_ARBITER_LOCK_EN lets a locked winner be
// re-granted on the following idle cycle, bypassing rotation.
module bus_rr_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write_enable,
  input  logic [NUM_REQ-1:0]            req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          m_valid,
  output logic                          m_write_enable,
  output logic [ADDR_WIDTH-1:0]         m_addr,
  output logic [DATA_WIDTH-1:0]         m_data,
  input  logic                          m_ready,
  input  logic [DATA_WIDTH-1:0]         m_rdata
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  arb_state_t             state, state_nxt;
  logic [IDX_W-1:0]       last_grant;
  logic [IDX_W-1:0]       pick_idx, win_idx;
  logic [NUM_REQ-1:0]     pick_gnt, win_gnt;
  logic                   pick_any, win_any;
  logic                   accept;
  logic [ADDR_WIDTH-1:0]  cmd_addr;
  logic [DATA_WIDTH-1:0]  cmd_data;
  logic                   cmd_we;
  logic [DATA_WIDTH-1:0]  rsp_data_q;

  bus_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req        (req_valid),
    .last_grant (last_grant),
    .gnt        (pick_gnt),
    .gnt_idx    (pick_idx),
    .gnt_any    (pick_any)
  );

`ifdef BUS_RR_ARBITER_LOCK_EN
  logic lock_hold;
  logic lock_hit;

  // A held lock re-grants the previous winner (last_grant) if it still requests
  always_comb begin
    lock_hit = lock_hold && req_valid[last_grant];
    win_any  = lock_hit || pick_any;
    win_idx  = pick_idx;
    win_gnt  = pick_gnt;
    if (lock_hit) begin
      win_idx             = last_grant;
      win_gnt             = '0;
      win_gnt[last_grant] = 1'b1;
    end
  end

  // Lock is sampled at accept and only honoured on the very next idle cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    lock_hold <= 1'b0;
    else if (state == ARB_IDLE) lock_hold <= accept ? req_lock[win_idx] : 1'b0;
  end
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;

  // Pure round-robin: the picker result is the winner
  always_comb begin
    win_any = pick_any;
    win_idx = pick_idx;
    win_gnt = pick_gnt;
  end
`endif

  assign accept = (state == ARB_IDLE) && win_any;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE:  if (win_any) state_nxt = ARB_ISSUE;
      ARB_ISSUE: if (m_ready) state_nxt = ARB_RESP;
      ARB_RESP:  state_nxt = ARB_IDLE;
      default:   state_nxt = ARB_IDLE;
    endcase
  end

  // Command capture, grant history and read-data capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_addr   <= '0;
      cmd_data   <= '0;
      cmd_we     <= 1'b0;
      last_grant <= IDX_W'(NUM_REQ - 1);
      rsp_data_q <= '0;
    end else begin
      if (accept) begin
        cmd_addr   <= req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
        cmd_data   <= req_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
        cmd_we     <= req_write_enable[win_idx];
        last_grant <= win_idx;
      end
      if (state == ARB_ISSUE && m_ready && !cmd_we) rsp_data_q <= m_rdata;
    end
  end

  // Outputs decoded from state; the command registers feed the bus directly
  always_comb begin
    req_ready      = (state == ARB_IDLE) ? win_gnt : '0;
    m_valid        = (state == ARB_ISSUE);
    m_write_enable = cmd_we;
    m_addr         = cmd_addr;
    m_data         = cmd_data;
    rsp_data       = rsp_data_q;
    rsp_valid      = '0;
    if (state == ARB_RESP) rsp_valid[last_grant] = 1'b1;
  end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter (NUM_REQ=4, 32-bit addr, 8-bit data).
module tb_bus_rr_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   req_valid, req_write_enable, req_lock;
  logic [127:0] req_addr;
  logic [31:0]  req_data;
  logic [3:0]   req_ready, rsp_valid;
  logic [7:0]   rsp_data;
  logic         m_valid, m_write_enable;
  logic [31:0]  m_addr;
  logic [7:0]   m_data;
  logic         m_ready;
  logic [7:0]   m_rdata;

  int checks = 0;
  int errors = 0;

  bus_rr_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(32), .DATA_WIDTH(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_write_enable (req_write_enable),
    .req_lock         (req_lock),
    .req_addr         (req_addr),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .rsp_valid        (rsp_valid),
    .rsp_data         (rsp_data),
    .m_valid          (m_valid),
    .m_write_enable   (m_write_enable),
    .m_addr           (m_addr),
    .m_data           (m_data),
    .m_ready          (m_ready),
    .m_rdata          (m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [3:0] oh(input int i);
    logic [3:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seq[4];
    rst = 1'b1;
    req_valid = '0; req_write_enable = '0; req_lock = '0;
    req_addr = '0; req_data = '0; m_ready = 1'b0; m_rdata = '0;
    cyc(); cyc();
    #1;
    chk("rst_m_valid", 64'(m_valid), 64'(0));
    chk("rst_m_we", 64'(m_write_enable), 64'(0));
    chk("rst_m_addr", 64'(m_addr), 64'(0));
    chk("rst_m_data", 64'(m_data), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_data", 64'(rsp_data), 64'(0));
    cyc();
    rst = 1'b0;

    // Single write from requester 2, m_ready tied high
    m_ready = 1'b1;
    req_valid = 4'b0100; req_write_enable = 4'b0100;
    req_addr[2*32 +: 32] = 32'h10; req_data[2*8 +: 8] = 8'hA5;
    #1;
    chk("wr_req_ready", 64'(req_ready), 64'(4'b0100));
    cyc();
    req_valid = '0;
    #1;
    chk("wr_m_valid", 64'(m_valid), 64'(1));
    chk("wr_m_we", 64'(m_write_enable), 64'(1));
    chk("wr_m_addr", 64'(m_addr), 64'(32'h10));
    chk("wr_m_data", 64'(m_data), 64'(8'hA5));
    chk("wr_rsp_early", 64'(rsp_valid), 64'(0));
    cyc();
    #1;
    chk("wr_rsp_valid", 64'(rsp_valid), 64'(4'b0100));
    chk("wr_m_valid_off", 64'(m_valid), 64'(0));
    chk("wr_rsp_data_held", 64'(rsp_data), 64'(0));
    cyc();

    // Fresh reset, then all four held valid: grants 0,1,2,3,0 every 3 cycles
    rst = 1'b1; cyc(); rst = 1'b0;
    req_valid = 4'hF; req_write_enable = '0;
    for (int k = 0; k <= 12; k++) begin
      #1;
      chk($sformatf("rr_ready_%0d", k), 64'(req_ready),
          64'((k % 3 == 0) ? oh((k / 3) % 4) : 4'b0000));
      chk($sformatf("rr_rsp_%0d", k), 64'(rsp_valid),
          64'((k % 3 == 2) ? oh((k / 3) % 4) : 4'b0000));
      cyc();
    end
    req_valid = '0;
    cyc(); cyc();

    // Read from requester 1 with five wait cycles
    m_ready = 1'b0;
    req_valid = 4'b0010; req_addr[1*32 +: 32] = 32'h44;
    #1;
    chk("rd_req_ready", 64'(req_ready), 64'(4'b0010));
    cyc();
    req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("rd_wait_valid_%0d", k), 64'(m_valid), 64'(1));
      chk($sformatf("rd_wait_addr_%0d", k), 64'(m_addr), 64'(32'h44));
      chk($sformatf("rd_wait_rsp_%0d", k), 64'(rsp_valid), 64'(0));
      cyc();
    end
    m_ready = 1'b1; m_rdata = 8'h3C;
    #1;
    chk("rd_last_valid", 64'(m_valid), 64'(1));
    chk("rd_we", 64'(m_write_enable), 64'(0));
    cyc();
    m_ready = 1'b0; m_rdata = 8'h00;
    #1;
    chk("rd_rsp_valid", 64'(rsp_valid), 64'(4'b0010));
    chk("rd_rsp_data", 64'(rsp_data), 64'(8'h3C));
    cyc();
    #1;
    chk("rd_rsp_done", 64'(rsp_valid), 64'(0));
    chk("rd_rsp_data_hold", 64'(rsp_data), 64'(8'h3C));

    // Reset during ARB_ISSUE
    req_valid = 4'b0100;
    #1;
    chk("ri_req_ready", 64'(req_ready), 64'(4'b0100));
    cyc();
    req_valid = '0;
    #1;
    chk("ri_m_valid", 64'(m_valid), 64'(1));
    rst = 1'b1;
    #1;
    chk("ri_m_valid_async", 64'(m_valid), 64'(0));
    chk("ri_m_addr_async", 64'(m_addr), 64'(0));
    cyc();
    rst = 1'b0;
    m_ready = 1'b1;
    #1;
    chk("ri_no_rsp_0", 64'(rsp_valid), 64'(0));
    cyc();
    #1;
    chk("ri_no_rsp_1", 64'(rsp_valid), 64'(0));
    req_valid = 4'b1001;
    #1;
    chk("ri_next_grant", 64'(req_ready), 64'(4'b0001));
    cyc();
    req_valid = '0;
    cyc(); cyc();

    // Lock: requesters 1 and 2 held valid, requester 1 locked
`ifdef BUS_RR_ARBITER_LOCK_EN
    seq[0] = 1; seq[1] = 1; seq[2] = 1; seq[3] = 2;
`else
    seq[0] = 1; seq[1] = 2; seq[2] = 1; seq[3] = 2;
`endif
    req_valid = 4'b0110; req_lock = 4'b0010;
    for (int k = 0; k <= 9; k++) begin
      if (k == 6) req_lock = '0;
      #1;
      chk($sformatf("lk_ready_%0d", k), 64'(req_ready),
          64'((k % 3 == 0) ? oh(seq[k / 3]) : 4'b0000));
      cyc();
    end
    req_valid = '0;
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
